// File: rtl/procyon_lsu_arb.sv
// LSU issue arbiter: picks one of SQ / LQ replay / RS per cycle with fixed
// priority plus starvation escape, and registers the winner for LSU_EX.
module procyon_lsu_arb #(
  parameter int unsigned OPTN_DATA_WIDTH    = 32,
  parameter int unsigned OPTN_ADDR_WIDTH    = 32,
  parameter int unsigned OPTN_ROB_IDX_WIDTH = 5,
  parameter int unsigned OPTN_LQ_DEPTH      = 8,
  parameter int unsigned OPTN_SQ_DEPTH      = 8,
  parameter int unsigned OPTN_STARVE_LIMIT  = 4,
  parameter int unsigned PCYN_OP_WIDTH      = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_flush,
  input  logic                          i_ex_stall,

  input  logic                          i_rs_valid,
  input  logic [PCYN_OP_WIDTH-1:0]      i_rs_op,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_rs_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_rs_addr,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_rs_data,
  output logic                          o_rs_ack,

  input  logic                          i_replay_valid,
  input  logic [OPTN_LQ_DEPTH-1:0]      i_replay_select,
  input  logic [PCYN_OP_WIDTH-1:0]      i_replay_op,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_replay_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_replay_addr,
  output logic                          o_replay_ack,

  input  logic                          i_sq_valid,
  input  logic [OPTN_SQ_DEPTH-1:0]      i_sq_select,
  input  logic [PCYN_OP_WIDTH-1:0]      i_sq_op,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_sq_addr,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_sq_data,
  output logic                          o_sq_ack,

  output logic                          o_ex_valid,
  output logic [1:0]                    o_ex_src,
  output logic [PCYN_OP_WIDTH-1:0]      o_ex_op,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_ex_tag,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_ex_addr,
  output logic [OPTN_DATA_WIDTH-1:0]    o_ex_data,
  output logic [OPTN_LQ_DEPTH-1:0]      o_ex_lq_select,
  output logic [OPTN_SQ_DEPTH-1:0]      o_ex_sq_select
);

  localparam int unsigned CNT_W = $clog2(OPTN_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OPTN_STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_RS = 2'b00,
    SRC_RP = 2'b01,
    SRC_SQ = 2'b10
  } src_e;

  logic [CNT_W-1:0] rs_cnt, rs_cnt_next;
  logic [CNT_W-1:0] rp_cnt, rp_cnt_next;

  logic rs_req, rp_req;
  logic rs_starved, rp_starved;
  logic grant_rs, grant_rp, grant_sq, any_grant;

  src_e                          win_src;
  logic [PCYN_OP_WIDTH-1:0]      win_op;
  logic [OPTN_ROB_IDX_WIDTH-1:0] win_tag;
  logic [OPTN_ADDR_WIDTH-1:0]    win_addr;
  logic [OPTN_DATA_WIDTH-1:0]    win_data;
  logic [OPTN_LQ_DEPTH-1:0]      win_lq_sel;
  logic [OPTN_SQ_DEPTH-1:0]      win_sq_sel;

  src_e ex_src;

  // Speculative requesters are masked during flush; stores are not.
  assign rs_req     = i_rs_valid & ~i_flush;
  assign rp_req     = i_replay_valid & ~i_flush;
  assign rs_starved = (rs_cnt == CNT_MAX);
  assign rp_starved = (rp_cnt == CNT_MAX);

  always_comb begin
    grant_rs = 1'b0;
    grant_rp = 1'b0;
    grant_sq = 1'b0;
    if (!rst && !i_ex_stall) begin
      if (rs_req && rs_starved)      grant_rs = 1'b1;
      else if (rp_req && rp_starved) grant_rp = 1'b1;
      else if (i_sq_valid)           grant_sq = 1'b1;
      else if (rp_req)               grant_rp = 1'b1;
      else if (rs_req)               grant_rs = 1'b1;
    end
  end

  assign any_grant    = grant_rs | grant_rp | grant_sq;
  assign o_rs_ack     = grant_rs;
  assign o_replay_ack = grant_rp;
  assign o_sq_ack     = grant_sq;

  // Clear has precedence; a stalled cycle neither clears nor counts a loss.
  always_comb begin
    rs_cnt_next = rs_cnt;
    if (i_flush || !i_rs_valid || grant_rs)
      rs_cnt_next = '0;
    else if (!i_ex_stall && !rs_starved)
      rs_cnt_next = rs_cnt + CNT_W'(1);

    rp_cnt_next = rp_cnt;
    if (i_flush || !i_replay_valid || grant_rp)
      rp_cnt_next = '0;
    else if (!i_ex_stall && !rp_starved)
      rp_cnt_next = rp_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_cnt <= '0;
      rp_cnt <= '0;
    end else begin
      rs_cnt <= rs_cnt_next;
      rp_cnt <= rp_cnt_next;
    end
  end

  always_comb begin
    win_src    = SRC_RS;
    win_op     = i_rs_op;
    win_tag    = i_rs_tag;
    win_addr   = i_rs_addr;
    win_data   = i_rs_data;
    win_lq_sel = '0;
    win_sq_sel = '0;
    if (grant_sq) begin
      win_src    = SRC_SQ;
      win_op     = i_sq_op;
      win_tag    = '0;
      win_addr   = i_sq_addr;
      win_data   = i_sq_data;
      win_sq_sel = i_sq_select;
    end else if (grant_rp) begin
      win_src    = SRC_RP;
      win_op     = i_replay_op;
      win_tag    = i_replay_tag;
      win_addr   = i_replay_addr;
      win_data   = '0;
      win_lq_sel = i_replay_select;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_ex_valid     <= 1'b0;
      ex_src         <= SRC_RS;
      o_ex_op        <= '0;
      o_ex_tag       <= '0;
      o_ex_addr      <= '0;
      o_ex_data      <= '0;
      o_ex_lq_select <= '0;
      o_ex_sq_select <= '0;
    end else if (!i_ex_stall) begin
      o_ex_valid <= any_grant;
      if (any_grant) begin
        ex_src         <= win_src;
        o_ex_op        <= win_op;
        o_ex_tag       <= win_tag;
        o_ex_addr      <= win_addr;
        o_ex_data      <= win_data;
        o_ex_lq_select <= win_lq_sel;
        o_ex_sq_select <= win_sq_sel;
      end
    end else if (i_flush) begin
      // A held op survives a stalled flush only if it is a retiring store.
      o_ex_valid <= o_ex_valid & (ex_src == SRC_SQ);
    end
  end

  assign o_ex_src = ex_src;

endmodule

// File: tb/tb_procyon_lsu_arb.sv
// Directed, table-driven bench for procyon_lsu_arb with LIMIT=4.
module tb_procyon_lsu_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush, i_ex_stall;
  logic        i_rs_valid;
  logic [4:0]  i_rs_op, i_rs_tag;
  logic [31:0] i_rs_addr, i_rs_data;
  logic        o_rs_ack;
  logic        i_replay_valid;
  logic [7:0]  i_replay_select;
  logic [4:0]  i_replay_op, i_replay_tag;
  logic [31:0] i_replay_addr;
  logic        o_replay_ack;
  logic        i_sq_valid;
  logic [7:0]  i_sq_select;
  logic [4:0]  i_sq_op;
  logic [31:0] i_sq_addr, i_sq_data;
  logic        o_sq_ack;
  logic        o_ex_valid;
  logic [1:0]  o_ex_src;
  logic [4:0]  o_ex_op, o_ex_tag;
  logic [31:0] o_ex_addr, o_ex_data;
  logic [7:0]  o_ex_lq_select, o_ex_sq_select;

  procyon_lsu_arb #(
    .OPTN_DATA_WIDTH(32), .OPTN_ADDR_WIDTH(32), .OPTN_ROB_IDX_WIDTH(5),
    .OPTN_LQ_DEPTH(8), .OPTN_SQ_DEPTH(8), .OPTN_STARVE_LIMIT(4),
    .PCYN_OP_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_ex_stall(i_ex_stall),
    .i_rs_valid(i_rs_valid), .i_rs_op(i_rs_op), .i_rs_tag(i_rs_tag),
    .i_rs_addr(i_rs_addr), .i_rs_data(i_rs_data), .o_rs_ack(o_rs_ack),
    .i_replay_valid(i_replay_valid), .i_replay_select(i_replay_select),
    .i_replay_op(i_replay_op), .i_replay_tag(i_replay_tag),
    .i_replay_addr(i_replay_addr), .o_replay_ack(o_replay_ack),
    .i_sq_valid(i_sq_valid), .i_sq_select(i_sq_select), .i_sq_op(i_sq_op),
    .i_sq_addr(i_sq_addr), .i_sq_data(i_sq_data), .o_sq_ack(o_sq_ack),
    .o_ex_valid(o_ex_valid), .o_ex_src(o_ex_src), .o_ex_op(o_ex_op),
    .o_ex_tag(o_ex_tag), .o_ex_addr(o_ex_addr), .o_ex_data(o_ex_data),
    .o_ex_lq_select(o_ex_lq_select), .o_ex_sq_select(o_ex_sq_select)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       flush, stall, rs, rp, sq;
    logic [4:0] rp_tag;
    logic [7:0] rp_sel;
    logic [2:0] ack;     // {sq, replay, rs}
    logic       v;
    logic [1:0] src;
    logic [4:0] tag;
    logic [7:0] lq;
  } vec_t;

  localparam int unsigned NVEC = 33;
  vec_t vecs[NVEC];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  function automatic vec_t mk(input logic fl, st, rs, rp, sq,
                              input logic [4:0] rtag, input logic [7:0] rsel,
                              input logic [2:0] ack, input logic v,
                              input logic [1:0] src, input logic [4:0] tag,
                              input logic [7:0] lq);
    vec_t r;
    r.flush = fl; r.stall = st; r.rs = rs; r.rp = rp; r.sq = sq;
    r.rp_tag = rtag; r.rp_sel = rsel; r.ack = ack;
    r.v = v; r.src = src; r.tag = tag; r.lq = lq;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Registered payload implied by the source that won; per-source payloads are fixed below.
  task automatic check_out(input string pfx, input logic v, input logic [1:0] src,
                           input logic [4:0] tag, input logic [7:0] lq);
    logic [4:0]  eop;
    logic [31:0] eaddr, edata;
    logic [7:0]  esq;
    case (src)
      2'b00:   begin eop = 5'd1; eaddr = 32'h200; edata = 32'hAAAA; esq = 8'h00; end
      2'b01:   begin eop = 5'd2; eaddr = 32'h100; edata = 32'h0;    esq = 8'h00; end
      default: begin eop = 5'd3; eaddr = 32'h300; edata = 32'h5555; esq = 8'h04; end
    endcase
    check({pfx, "_valid"}, 32'(o_ex_valid), 32'(v));
    check({pfx, "_src"},   32'(o_ex_src),   32'(src));
    check({pfx, "_op"},    32'(o_ex_op),    32'(eop));
    check({pfx, "_tag"},   32'(o_ex_tag),   32'(tag));
    check({pfx, "_addr"},  o_ex_addr,       eaddr);
    check({pfx, "_data"},  o_ex_data,       edata);
    check({pfx, "_lqsel"}, 32'(o_ex_lq_select), 32'(lq));
    check({pfx, "_sqsel"}, 32'(o_ex_sq_select), 32'(esq));
  endtask

  task automatic drive(input vec_t x);
    i_flush = x.flush; i_ex_stall = x.stall;
    i_rs_valid = x.rs; i_replay_valid = x.rp; i_sq_valid = x.sq;
    i_replay_tag = x.rp_tag; i_replay_select = x.rp_sel;
  endtask

  initial begin
    vecs[0]  = mk(0,0,1,1,1, 5'd5, 8'h01, 3'b100, 1, 2'd2, 5'd0, 8'h00);
    vecs[1]  = mk(0,0,0,0,0, 5'd0, 8'h00, 3'b000, 0, 2'd2, 5'd0, 8'h00);
    vecs[2]  = mk(0,0,1,0,1, 5'd0, 8'h00, 3'b100, 1, 2'd2, 5'd0, 8'h00);
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = vecs[2];
    vecs[6]  = mk(0,0,1,0,1, 5'd0, 8'h00, 3'b001, 1, 2'd0, 5'd7, 8'h00);
    vecs[7]  = vecs[2];
    vecs[8]  = vecs[1];
    vecs[9]  = mk(0,0,1,1,1, 5'd5, 8'h02, 3'b100, 1, 2'd2, 5'd0, 8'h00);
    vecs[10] = vecs[9];
    vecs[11] = vecs[9];
    vecs[12] = vecs[9];
    vecs[13] = mk(0,0,1,1,1, 5'd5, 8'h02, 3'b001, 1, 2'd0, 5'd7, 8'h00);
    vecs[14] = mk(0,0,1,1,1, 5'd5, 8'h02, 3'b010, 1, 2'd1, 5'd5, 8'h02);
    vecs[15] = mk(0,0,0,0,0, 5'd0, 8'h00, 3'b000, 0, 2'd1, 5'd5, 8'h02);
    vecs[16] = mk(0,0,0,1,0, 5'd5, 8'h01, 3'b010, 1, 2'd1, 5'd5, 8'h01);
    vecs[17] = mk(0,1,0,0,1, 5'd0, 8'h00, 3'b000, 1, 2'd1, 5'd5, 8'h01);
    vecs[18] = vecs[17];
    vecs[19] = vecs[17];
    vecs[20] = vecs[2];
    vecs[20].rs = 1'b0;
    vecs[21] = mk(0,0,0,1,0, 5'd1, 8'h01, 3'b010, 1, 2'd1, 5'd1, 8'h01);
    vecs[22] = mk(0,0,0,1,0, 5'd2, 8'h02, 3'b010, 1, 2'd1, 5'd2, 8'h02);
    vecs[23] = mk(0,0,0,1,0, 5'd3, 8'h04, 3'b010, 1, 2'd1, 5'd3, 8'h04);
    vecs[24] = mk(0,0,0,1,0, 5'd4, 8'h08, 3'b010, 1, 2'd1, 5'd4, 8'h08);
    vecs[25] = mk(0,0,0,0,0, 5'd0, 8'h00, 3'b000, 0, 2'd1, 5'd4, 8'h08);
    vecs[26] = mk(1,0,1,1,1, 5'd3, 8'h04, 3'b100, 1, 2'd2, 5'd0, 8'h00);
    vecs[27] = mk(0,0,0,1,0, 5'd6, 8'h10, 3'b010, 1, 2'd1, 5'd6, 8'h10);
    vecs[28] = mk(1,1,1,1,1, 5'd6, 8'h10, 3'b000, 0, 2'd1, 5'd6, 8'h10);
    vecs[29] = mk(0,0,0,0,0, 5'd0, 8'h00, 3'b000, 0, 2'd1, 5'd6, 8'h10);
    vecs[30] = mk(0,0,0,0,1, 5'd0, 8'h00, 3'b100, 1, 2'd2, 5'd0, 8'h00);
    vecs[31] = mk(1,1,0,0,0, 5'd0, 8'h00, 3'b000, 1, 2'd2, 5'd0, 8'h00);
    vecs[32] = vecs[1];

    i_rs_op = 5'd1; i_rs_tag = 5'd7; i_rs_addr = 32'h200; i_rs_data = 32'hAAAA;
    i_replay_op = 5'd2; i_replay_addr = 32'h100;
    i_sq_op = 5'd3; i_sq_select = 8'h04; i_sq_addr = 32'h300; i_sq_data = 32'h5555;

    // Reset held two cycles with every requester asserting.
    rst = 1'b1; i_flush = 1'b0; i_ex_stall = 1'b0;
    i_rs_valid = 1'b1; i_replay_valid = 1'b1; i_sq_valid = 1'b1;
    i_replay_tag = 5'd5; i_replay_select = 8'h01;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("rst%0d_acks", c), 32'({o_sq_ack, o_replay_ack, o_rs_ack}), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    i_rs_valid = 1'b0; i_replay_valid = 1'b0; i_sq_valid = 1'b0;
    #1;
    check("rst_valid", 32'(o_ex_valid), 32'd0);
    check("rst_src",   32'(o_ex_src), 32'd0);
    check("rst_payload", 32'(o_ex_op) | 32'(o_ex_tag) | o_ex_addr | o_ex_data, 32'd0);
    check("rst_sels",  32'({o_ex_lq_select, o_ex_sq_select}), 32'd0);

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_acks", i), 32'({o_sq_ack, o_replay_ack, o_rs_ack}), 32'(vecs[i].ack));
      @(posedge clk); #1;
      check_out($sformatf("v%0d", i), vecs[i].v, vecs[i].src, vecs[i].tag, vecs[i].lq);
    end

    // Reset during a stall must discard the held replay.
    drive(mk(0,0,0,1,0, 5'd9, 8'h01, 3'b000, 0, 2'd0, 5'd0, 8'h00));
    #1;
    check("rstst_grant", 32'(o_replay_ack), 32'd1);
    @(posedge clk); #1;
    check("rstst_held_tag", 32'(o_ex_tag), 32'd9);
    i_replay_valid = 1'b0; i_sq_valid = 1'b1; i_ex_stall = 1'b1; rst = 1'b1;
    #1;
    check("rstst_acks", 32'({o_sq_ack, o_replay_ack, o_rs_ack}), 32'd0);
    @(posedge clk); #1;
    check("rstst_valid", 32'(o_ex_valid), 32'd0);
    check("rstst_payload", 32'(o_ex_tag) | o_ex_addr | 32'(o_ex_lq_select), 32'd0);
    rst = 1'b0; i_ex_stall = 1'b0;
    #1;
    check("rstst_sq_after", 32'(o_sq_ack), 32'd1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
